// File: rtl/salsa20_core.sv
// Salsa20 keystream-block generator: one double round per clock, then feed-forward add.
// Latency: out_valid rises DOUBLE_ROUNDS+1 cycles after the accept edge.
// Backpressure: out_block is held with out_valid high until out_ready; no new request is taken meanwhile.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid/ready   request handshake; key/nonce/counter are sampled on the accept edge only
//   key, nonce,      k_i = key[32*i+:32], n0/n1 = nonce halves, c0/c1 = counter halves
//   counter
//   out_valid/ready  result handshake; out_block word i = out_block[32*i+:32]
//   busy             high from the first round until the result is handed off

module salsa20_doubleround (
    input  logic [511:0] din,
    output logic [511:0] dout
);
    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Returns {z3, z2, z1, z0} for input order (y0, y1, y2, y3).
    function automatic logic [127:0] qr(input logic [31:0] y0, input logic [31:0] y1,
                                        input logic [31:0] y2, input logic [31:0] y3);
        logic [31:0] z0, z1, z2, z3;
        z1 = y1 ^ rotl(y0 + y3, 7);
        z2 = y2 ^ rotl(z1 + y0, 9);
        z3 = y3 ^ rotl(z2 + z1, 13);
        z0 = y0 ^ rotl(z3 + z2, 18);
        return {z3, z2, z1, z0};
    endfunction

    logic [31:0] x [16];
    logic [31:0] c [16];
    logic [31:0] r [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            x[i] = din[32*i +: 32];
        end
        // Column round: each quarter round starts on the diagonal element.
        {c[12], c[8],  c[4],  c[0]}  = qr(x[0],  x[4],  x[8],  x[12]);
        {c[1],  c[13], c[9],  c[5]}  = qr(x[5],  x[9],  x[13], x[1]);
        {c[6],  c[2],  c[14], c[10]} = qr(x[10], x[14], x[2],  x[6]);
        {c[11], c[7],  c[3],  c[15]} = qr(x[15], x[3],  x[7],  x[11]);
        // Row round: the transpose of the column round.
        {r[3],  r[2],  r[1],  r[0]}  = qr(c[0],  c[1],  c[2],  c[3]);
        {r[4],  r[7],  r[6],  r[5]}  = qr(c[5],  c[6],  c[7],  c[4]);
        {r[9],  r[8],  r[11], r[10]} = qr(c[10], c[11], c[8],  c[9]);
        {r[14], r[13], r[12], r[15]} = qr(c[15], c[12], c[13], c[14]);
        dout = '0;
        for (int i = 0; i < 16; i++) begin
            dout[32*i +: 32] = r[i];
        end
    end
endmodule

module salsa20_core #(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [63:0]  nonce,
    input  logic [63:0]  counter,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         busy
);
    // "expand 32-byte k"
    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;
    localparam logic [3:0]  LAST_ROUND = 4'(DOUBLE_ROUNDS - 1);

    // FINAL is the single cycle between the last round and the result register.
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t       state, next_state;
    logic [3:0]   round_cnt;
    logic [511:0] work, init, matrix, dr_out, sum;

    // Word 0 sits in the LSBs, so the concatenation lists word 15 first.
    assign matrix = {SIGMA3, key[255:128], SIGMA2, counter, nonce, SIGMA1, key[127:0], SIGMA0};

    salsa20_doubleround u_dr (
        .din  (work),
        .dout (dr_out)
    );

    // Feed-forward: independent 32-bit adds, no carry between words.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum[32*i +: 32] = work[32*i +: 32] + init[32*i +: 32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = ROUND;
            ROUND:   if (round_cnt == LAST_ROUND) next_state = FINAL;
            FINAL:   next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decode straight from state so a reset drops out_valid without waiting for a clock.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work      <= '0;
            init      <= '0;
            round_cnt <= '0;
            out_block <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work      <= matrix;
                        init      <= matrix;
                        round_cnt <= '0;
                    end
                end
                ROUND: begin
                    work      <= dr_out;
                    round_cnt <= round_cnt + 4'd1;
                end
                FINAL: begin
                    out_block <= sum;
                end
                default: begin
                end
            endcase
        end
    end
endmodule
